// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder.
// Stage count and configuration-legality helpers are evaluated at elaboration time.
package adder_pkg;

  localparam int unsigned DEFAULT_STAGE_W = 4;

  typedef logic [DEFAULT_STAGE_W-1:0] chunk_t;

  function automatic int unsigned stages(input int unsigned width, input int unsigned stage_w);
    return width / stage_w;
  endfunction

  function automatic bit width_ok(input int unsigned width, input int unsigned stage_w);
    return (stage_w != 0) && (width >= stage_w) && ((width % stage_w) == 0);
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One registered chunk adder: chunk sum, carry-out and valid are captured when en is high.
module adder_stage #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         out_valid
);

  logic [W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      sum       <= total[W-1:0];
      cout      <= total[W];
      out_valid <= in_valid;
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder pipelined STAGE_W bits per stage with valid/ready on both sides.
// Define ADDSUB_EN to add the Sub port (A - B - Cin when Sub=1).
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned STAGE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef ADDSUB_EN
  input  logic             Sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int unsigned STAGES = stages(WIDTH, STAGE_W);

  if (!width_ok(WIDTH, STAGE_W)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGE_W");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Whole pipeline advances together; a stalled output freezes every stage.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en & ~rst;

`ifdef ADDSUB_EN
  // Subtract as A + ~B + ~Cin; inverting at entry lets Sub travel implicitly with the op.
  assign b_eff   = B ^ {WIDTH{Sub}};
  assign cin_eff = Cin ^ Sub;
`else
  assign b_eff   = B;
  assign cin_eff = Cin;
`endif

  if (STAGES == 1) begin : g_single
    adder_stage #(
      .W (STAGE_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (in_valid),
      .a         (A),
      .b         (b_eff),
      .cin       (cin_eff),
      .sum       (S),
      .cout      (Cout),
      .out_valid (out_valid)
    );
  end else begin : g_multi
    localparam int unsigned HiW = WIDTH - STAGE_W;

    logic [WIDTH-1:0]   a_in      [STAGES];
    logic [WIDTH-1:0]   b_in      [STAGES];
    logic               c_in      [STAGES];
    logic               v_in      [STAGES];
    logic [STAGE_W-1:0] stage_sum [STAGES];
    logic               stage_co  [STAGES];
    logic               stage_v   [STAGES];
    logic [HiW-1:0]     a_hi_q    [STAGES];
    logic [HiW-1:0]     b_hi_q    [STAGES];

    assign a_in[0] = A;
    assign b_in[0] = b_eff;
    assign c_in[0] = cin_eff;
    assign v_in[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_stage #(
        .W (STAGE_W)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (v_in[k]),
        .a         (a_in[k][STAGE_W-1:0]),
        .b         (b_in[k][STAGE_W-1:0]),
        .cin       (c_in[k]),
        .sum       (stage_sum[k]),
        .cout      (stage_co[k]),
        .out_valid (stage_v[k])
      );

      always_ff @(posedge clk) begin
        if (rst) begin
          a_hi_q[k] <= '0;
          b_hi_q[k] <= '0;
        end else if (en) begin
          a_hi_q[k] <= a_in[k][WIDTH-1:STAGE_W];
          b_hi_q[k] <= b_in[k][WIDTH-1:STAGE_W];
        end
      end

      // A rotates right: finished sum chunks enter at the top, so after the last stage
      // the A skew register has become the deskewed lower part of S.
      if (k + 1 < STAGES) begin : g_link
        assign a_in[k+1] = {stage_sum[k], a_hi_q[k]};
        assign b_in[k+1] = {{STAGE_W{1'b0}}, b_hi_q[k]};
        assign c_in[k+1] = stage_co[k];
        assign v_in[k+1] = stage_v[k];
      end
    end

    assign S         = {stage_sum[STAGES-1], a_hi_q[STAGES-1]};
    assign Cout      = stage_co[STAGES-1];
    assign out_valid = stage_v[STAGES-1];
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGE_W=4): vector table,
// hand-written stall/reset sequences and a queue-based scoreboard over random traffic.
module tb_pipelined_adder;

  localparam int W       = 16;
  localparam int LATENCY = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          Cin;
  logic          sub_r;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  S;
  logic          Cout;

  pipelined_adder #(
    .WIDTH   (W),
    .STAGE_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
`ifdef ADDSUB_EN
    .Sub       (sub_r),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
  } vec_t;

  typedef struct {
    logic [W:0] res;
    int         cyc;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_done = 0;
  bit   chk_lat = 1'b1;
  exp_t exp_q[$];

  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_s;
  logic         prev_c;

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    int unsigned r;
    if (sub) r = int'(a) + (32'hFFFF - int'(b)) + (1 - int'(cin));
    else     r = int'(a) + int'(b) + int'(cin);
    return r[W:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: orders, values, latency, stall hold and backpressure.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got S=%h Cout=%b, want no output", S, Cout);
      end else begin
        e = exp_q.pop_front();
        n_done++;
        if ({Cout, S} !== e.res) begin
          errors++;
          $display("FAIL sb_result got {Cout,S}=%h, want %h", {Cout, S}, e.res);
        end
        if (chk_lat) begin
          checks++;
          if (cyc - e.cyc != LATENCY) begin
            errors++;
            $display("FAIL latency got %0d, want %0d", cyc - e.cyc, LATENCY);
          end
        end
      end
    end
    if (prev_stall && rst !== 1'b1) begin
      checks++;
      if (out_valid !== 1'b1 || S !== prev_s || Cout !== prev_c) begin
        errors++;
        $display("FAIL stall_hold got v=%b S=%h C=%b, want v=1 S=%h C=%b",
                 out_valid, S, Cout, prev_s, prev_c);
      end
    end
    if (out_valid === 1'b1 && out_ready === 1'b0) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready got %b, want 0", in_ready);
      end
    end
    prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0) && (rst !== 1'b1);
    prev_s     = S;
    prev_c     = Cout;
    if (rst === 1'b1) exp_q.delete();
    else if (in_valid === 1'b1 && in_ready === 1'b1) begin
      e.res = model(A, B, Cin, sub_r);
      e.cyc = cyc;
      exp_q.push_back(e);
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic s);
    int n = 0;
    bit acc = 1'b0;
    A = a; B = b; Cin = c; sub_r = s; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout got no accept in %0d cycles, want accept", n);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending, want 0", exp_q.size());
    end
  endtask

  vec_t         vecs[$];
  logic [W-1:0] ra[8];
  logic [W-1:0] rb[8];
  logic         rc[8];

  initial begin
    int n;
    int base;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; sub_r = 1'b0;

    vecs.push_back('{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0003, 16'h000B, 1'b1, 1'b0, 16'h000F, 1'b0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0});
`ifdef ADDSUB_EN
    vecs.push_back('{16'h0003, 16'h000B, 1'b0, 1'b1, 16'hFFF8, 1'b0});
    vecs.push_back('{16'h000B, 16'h0003, 1'b0, 1'b1, 16'h0008, 1'b1});
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready got %b, want 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b, want 0", out_valid); end
    if (S !== '0)           begin errors++; $display("FAIL rst_S got %h, want 0", S); end
    if (Cout !== 1'b0)      begin errors++; $display("FAIL rst_Cout got %b, want 0", Cout); end
    @(posedge clk); #1 rst = 1'b0;

    // Vector table, one op at a time
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      in_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (out_valid !== 1'b1 && n < 20);
      checks++;
      if (out_valid !== 1'b1 || S !== vecs[i].s || Cout !== vecs[i].cout) begin
        errors++;
        $display("FAIL vec%0d got v=%b S=%h C=%b, want v=1 S=%h C=%b",
                 i, out_valid, S, Cout, vecs[i].s, vecs[i].cout);
      end
      @(posedge clk); #1;
    end
    drain();

    // 8 back-to-back ops, full throughput
    for (int i = 0; i < 8; i++) begin
      ra[i] = W'($urandom); rb[i] = W'($urandom); rc[i] = 1'($urandom);
    end
    base = n_done;
    for (int i = 0; i < 8; i++) send(ra[i], rb[i], rc[i], 1'b0);
    in_valid = 1'b0;
    drain();
    checks++;
    if (n_done - base != 8) begin
      errors++;
      $display("FAIL b2b_count got %0d, want 8", n_done - base);
    end

    // Same 8 ops with out_ready low for 4 cycles mid-stream
    chk_lat = 1'b0;
    base = n_done;
    begin
      int i = 0;
      for (int t = 0; t < 60 && i < 8; t++) begin
        out_ready = !(t >= 5 && t < 9);
        A = ra[i]; B = rb[i]; Cin = rc[i]; sub_r = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        if (in_ready === 1'b1) i++;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    checks++;
    if (n_done - base != 8) begin
      errors++;
      $display("FAIL stall_count got %0d, want 8", n_done - base);
    end
    chk_lat = 1'b1;

    // Reset with 3 ops in flight
    base = n_done;
    for (int i = 0; i < 3; i++) send(ra[i], rb[i], rc[i], 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready got %b, want 0", in_ready); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (S !== '0 || Cout !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_data got S=%h C=%b, want 0 0", S, Cout);
    end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b, want 0", out_valid); end
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_flush got out_valid=%b, want 0", out_valid); end
    end
    checks++;
    if (n_done != base) begin
      errors++;
      $display("FAIL rst_emitted got %0d results, want 0", n_done - base);
    end
    @(posedge clk); #1;

    // Random traffic with random backpressure
    chk_lat = 1'b0;
    for (int t = 0; t < 300; t++) begin
      out_ready = 1'($urandom_range(0, 3) != 0);
      in_valid  = 1'($urandom_range(0, 3) != 0);
      A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
`ifdef ADDSUB_EN
      sub_r = 1'($urandom);
`else
      sub_r = 1'b0;
`endif
      if (t % 50 == 0) begin A = 16'hFFFF; B = 16'h0000; Cin = 1'b1; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
